multicyc_ctrl_fsm: RTL and testbench
====================================

Name: multicyc_ctrl_fsm

Overview:
Parametrised multicycle MIPS control unit, the successor to the fixed multicycle controller. It adds three things: a memory request/ready handshake with wait states, a watchdog timeout on memory, and BNE support. It also adds an illegal-opcode trap that can be switched off. It sits between the instruction register (opcode/funct) and the multicycle datapath, and drives every mux select and write strobe.

Parameters:
TIMEOUT, 16, consecutive not-ready request cycles before a bus-timeout trap; 0 disables the watchdog
TRAP_EN, 1, 1: illegal opcode enters Trap; 0: illegal opcode is treated as a NOP (Decode -> Fetch)
ALUOP_W, 4, width of alu_op

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
opcode  in  6  IR[31:26]; stable outside Fetch
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request
mem_we  out  1  write qualifier for mem_req
mem_addr_sel  out  1  0 PC, 1 ALUout
ir_we  out  1  instruction register load
pc_we  out  1  PC load
alu_srca_sel  out  1  0 PC, 1 Rs
alu_srcb_sel  out  2  0 Rt, 1 Four, 2 Imm, 3 BeqImm
alu_op  out  ALUOP_W  0 ADD, 1 SUB, 2 ADDU, 3 AND, 4 OR, 5 XOR, 6 RR (funct-decoded)
imm_zext  out  1  zero-extend the immediate (logical immediates)
reg_we  out  1  register file write
wreg_dst_sel  out  1  0 Rt, 1 Rd
wrbck_data_sel  out  1  0 ALUout, 1 MemData
nxt_pc_sel  out  2  0 PCPlus4, 1 PCBranch, 2 PCJmp
trap  out  1  sticky trap flag
trap_cause  out  2  0 none, 1 illegal opcode, 2 bus timeout
state_o  out  4  current state, for debug

Behaviour:
- Opcodes: RR 000000, LW 100011, SW 101011, BEQ 000100, BNE 000101, J 000010, ADDI 001000, ADDIU 001001, ANDI 001100, ORI 001101, XORI 001110. Every other opcode is illegal.
- States: Fetch, Decode, MemAddr, MemRd, MemWrbck, MemWr, RRExec, RRWrbck, Branch, Jmp, RIExec, RIWrbck, Trap.
- Registered state only; outputs are combinational from state, opcode, zero and mem_ready. Unlisted outputs are 0.
- Reset:
  - While rst=1: state=Fetch, watchdog counter=0, trap=0, trap_cause=0.
  - All strobes (mem_req, mem_we, ir_we, pc_we, reg_we) are forced to 0.
  - First mem_req is in the first cycle after deassertion.
  - Reset mid-transaction abandons it with no further strobes.
- Fetch:
  - mem_req=1, mem_addr_sel=PC, srca=PC, srcb=Four, alu_op=ADD, nxt_pc_sel=PCPlus4.
  - Hold until mem_ready. In the cycle mem_ready=1: ir_we=1, pc_we=1, then go to Decode.
- Decode:
  - srca=PC, srcb=BeqImm, ADD (branch-target precompute).
  - Next state: LW/SW -> MemAddr; RR -> RRExec; BEQ/BNE -> Branch; J -> Jmp; ADDI..XORI -> RIExec.
  - Illegal opcode: Trap with cause 1 if TRAP_EN, else Fetch.
- MemAddr: srca=Rs, srcb=Imm, ADD. Go to MemRd for LW, MemWr for SW.
- MemRd: mem_req=1, addr=ALUout; hold until mem_ready, then MemWrbck.
- MemWrbck: reg_we=1, dst=Rt, data=MemData, then Fetch.
- MemWr: mem_req=1, mem_we=1, addr=ALUout; hold until mem_ready, then Fetch.
- RRExec: srca=Rs, srcb=Rt, alu_op=RR, then RRWrbck. RRWrbck: reg_we=1, dst=Rd, data=ALUout, then Fetch.
- Branch:
  - srca=Rs, srcb=Rt, SUB, nxt_pc_sel=PCBranch.
  - pc_we = zero for BEQ, ~zero for BNE. Then Fetch.
- Jmp: nxt_pc_sel=PCJmp, pc_we=1, then Fetch.
- RIExec:
  - srca=Rs, srcb=Imm.
  - alu_op: ADDI->ADD, ADDIU->ADDU, ANDI->AND, ORI->OR, XORI->XOR. imm_zext=1 for ANDI/ORI/XORI.
  - Then RIWrbck, which holds the same srca/srcb/alu_op/imm_zext, plus reg_we=1, dst=Rt, data=ALUout. Then Fetch.
- Watchdog (TIMEOUT>0):
  - Counter width clog2(TIMEOUT+1). Increments each cycle with mem_req=1 and mem_ready=0.
  - Clears on mem_ready=1 and on any cycle without mem_req.
  - When TIMEOUT consecutive not-ready request cycles are reached, the next state is Trap with cause 2. mem_ready arriving on cycle TIMEOUT+1 is too late.
  - If mem_ready=1 on cycle TIMEOUT, it completes normally.
- Trap:
  - All strobes 0, trap=1, trap_cause held.
  - Exit only by reset. mem_ready, zero and opcode are ignored.
- mem_ready while mem_req=0 is ignored and never causes a transition.
- Cycle counts with zero wait states: R-type/RI 4, LW 5, SW 4, BEQ/BNE/J 3. Each memory wait adds 1.

Test Plan:
- Reset with rst pulsed mid-MemRd wait -> strobes drop asynchronously; state_o=Fetch; first mem_req on the cycle after deassert; trap=0.
- ADDI then ORI, mem_ready tied 1 -> 4 cycles each; alu_op 0 then 4; imm_zext 0 then 1; reg_we only in RIWrbck with wreg_dst_sel=0.
- LW with mem_ready delayed 3 cycles in both Fetch and MemRd -> ir_we/pc_we asserted exactly once, in the ready cycle; LW takes 11 cycles total; reg_we with wrbck_data_sel=1.
- BEQ zero=1, BEQ zero=0, BNE zero=0, BNE zero=1 -> pc_we 1,0,1,0 in Branch with nxt_pc_sel=1; J -> pc_we=1, nxt_pc_sel=2.
- Opcode 111111 -> TRAP_EN=1: trap=1, cause=1, no strobes for 20 cycles; TRAP_EN=0: returns to Fetch after 2 cycles.
- TIMEOUT=4, SW with mem_ready low -> Trap with cause 2 after 4 request cycles; repeat with ready on cycle 4 -> no trap; TIMEOUT=0 with 100 cycles of waiting -> no trap.

Source files
------------

// File: rtl/multicyc_ctrl_fsm.sv
// multicyc_ctrl_fsm -- multicycle MIPS control unit.
//
// Sequences each instruction through Fetch/Decode/execute/writeback states
// and drives every datapath mux select and write strobe. Memory accesses use
// a request/ready handshake with wait states, guarded by an optional watchdog
// that traps when memory does not answer. Illegal opcodes can trap or be
// skipped as NOPs.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   opcode          IR[31:26], stable outside Fetch
//   zero            ALU zero flag (branch condition)
//   mem_ready       memory completes the current request this cycle
//   mem_req/mem_we  memory request and write qualifier
//   mem_addr_sel    0 PC, 1 ALUout
//   ir_we, pc_we    instruction register / PC load
//   alu_srca_sel    0 PC, 1 Rs
//   alu_srcb_sel    0 Rt, 1 Four, 2 Imm, 3 BeqImm
//   alu_op          0 ADD, 1 SUB, 2 ADDU, 3 AND, 4 OR, 5 XOR, 6 RR
//   imm_zext        zero-extend the immediate
//   reg_we          register file write
//   wreg_dst_sel    0 Rt, 1 Rd
//   wrbck_data_sel  0 ALUout, 1 MemData
//   nxt_pc_sel      0 PCPlus4, 1 PCBranch, 2 PCJmp
//   trap            sticky trap flag (cleared only by reset)
//   trap_cause      0 none, 1 illegal opcode, 2 bus timeout
//   state_o         current state, for debug
`timescale 1ns/1ps
module multicyc_ctrl_fsm #(
  parameter int TIMEOUT = 16,
  parameter bit TRAP_EN = 1'b1,
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               mem_addr_sel,
  output logic               ir_we,
  output logic               pc_we,
  output logic               alu_srca_sel,
  output logic [1:0]         alu_srcb_sel,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               imm_zext,
  output logic               reg_we,
  output logic               wreg_dst_sel,
  output logic               wrbck_data_sel,
  output logic [1:0]         nxt_pc_sel,
  output logic               trap,
  output logic [1:0]         trap_cause,
  output logic [3:0]         state_o
);

  localparam logic [3:0] ST_FETCH    = 4'd0;
  localparam logic [3:0] ST_DECODE   = 4'd1;
  localparam logic [3:0] ST_MEMADDR  = 4'd2;
  localparam logic [3:0] ST_MEMRD    = 4'd3;
  localparam logic [3:0] ST_MEMWRBCK = 4'd4;
  localparam logic [3:0] ST_MEMWR    = 4'd5;
  localparam logic [3:0] ST_RREXEC   = 4'd6;
  localparam logic [3:0] ST_RRWRBCK  = 4'd7;
  localparam logic [3:0] ST_BRANCH   = 4'd8;
  localparam logic [3:0] ST_JMP      = 4'd9;
  localparam logic [3:0] ST_RIEXEC   = 4'd10;
  localparam logic [3:0] ST_RIWRBCK  = 4'd11;
  localparam logic [3:0] ST_TRAP     = 4'd12;

  localparam logic [5:0] OP_RR    = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;

  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_ADDU = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_XOR  = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] ALU_RR   = ALUOP_W'(6);

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  logic [3:0] stateReg, stateNext;
  logic [1:0] causeReg, causeNext;
  logic       memReqRaw;
  logic       wdExpire;

  // The three states that talk to memory; the watchdog only runs here.
  assign memReqRaw = (stateReg == ST_FETCH) || (stateReg == ST_MEMRD) ||
                     (stateReg == ST_MEMWR);

  generate
    if (TIMEOUT > 0) begin : gWatchdog
      localparam int WD_W = $clog2(TIMEOUT + 1);
      localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
      logic [WD_W-1:0] wdCntReg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          wdCntReg <= '0;
        end else if (memReqRaw && !mem_ready) begin
          wdCntReg <= wdCntReg + 1'b1;
        end else begin
          wdCntReg <= '0;
        end
      end

      // Fires on the TIMEOUT-th consecutive unanswered cycle, so ready in
      // that same cycle still wins.
      assign wdExpire = memReqRaw && !mem_ready && (wdCntReg == WD_LAST);
    end else begin : gNoWatchdog
      assign wdExpire = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg <= ST_FETCH;
      causeReg <= 2'd0;
    end else begin
      stateReg <= stateNext;
      causeReg <= causeNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    causeNext = causeReg;
    case (stateReg)
      ST_FETCH: begin
        if (mem_ready) begin
          stateNext = ST_DECODE;
        end else if (wdExpire) begin
          stateNext = ST_TRAP;
          causeNext = CAUSE_TIMEOUT;
        end
      end
      ST_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:   stateNext = ST_MEMADDR;
          OP_RR:          stateNext = ST_RREXEC;
          OP_BEQ, OP_BNE: stateNext = ST_BRANCH;
          OP_J:           stateNext = ST_JMP;
          OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: stateNext = ST_RIEXEC;
          default: begin
            if (TRAP_EN) begin
              stateNext = ST_TRAP;
              causeNext = CAUSE_ILLEGAL;
            end else begin
              stateNext = ST_FETCH;
            end
          end
        endcase
      end
      ST_MEMADDR:  stateNext = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD: begin
        if (mem_ready) begin
          stateNext = ST_MEMWRBCK;
        end else if (wdExpire) begin
          stateNext = ST_TRAP;
          causeNext = CAUSE_TIMEOUT;
        end
      end
      ST_MEMWRBCK: stateNext = ST_FETCH;
      ST_MEMWR: begin
        if (mem_ready) begin
          stateNext = ST_FETCH;
        end else if (wdExpire) begin
          stateNext = ST_TRAP;
          causeNext = CAUSE_TIMEOUT;
        end
      end
      ST_RREXEC:   stateNext = ST_RRWRBCK;
      ST_RRWRBCK:  stateNext = ST_FETCH;
      ST_BRANCH:   stateNext = ST_FETCH;
      ST_JMP:      stateNext = ST_FETCH;
      ST_RIEXEC:   stateNext = ST_RIWRBCK;
      ST_RIWRBCK:  stateNext = ST_FETCH;
      ST_TRAP:     stateNext = ST_TRAP;
      default:     stateNext = ST_FETCH;
    endcase
  end

  // ALU function for register-immediate instructions.
  logic [ALUOP_W-1:0] riAluOp;
  logic               riZext;
  always_comb begin
    riAluOp = ALU_ADD;
    riZext  = 1'b0;
    case (opcode)
      OP_ADDIU: riAluOp = ALU_ADDU;
      OP_ANDI: begin riAluOp = ALU_AND; riZext = 1'b1; end
      OP_ORI:  begin riAluOp = ALU_OR;  riZext = 1'b1; end
      OP_XORI: begin riAluOp = ALU_XOR; riZext = 1'b1; end
      default: riAluOp = ALU_ADD;
    endcase
  end

  logic irWeRaw, pcWeRaw, regWeRaw, memWeRaw;

  always_comb begin
    irWeRaw        = 1'b0;
    pcWeRaw        = 1'b0;
    regWeRaw       = 1'b0;
    memWeRaw       = 1'b0;
    mem_addr_sel   = 1'b0;
    alu_srca_sel   = 1'b0;
    alu_srcb_sel   = 2'd0;
    alu_op         = ALU_ADD;
    imm_zext       = 1'b0;
    wreg_dst_sel   = 1'b0;
    wrbck_data_sel = 1'b0;
    nxt_pc_sel     = 2'd0;
    case (stateReg)
      ST_FETCH: begin
        alu_srcb_sel = 2'd1;
        irWeRaw      = mem_ready;
        pcWeRaw      = mem_ready;
      end
      ST_DECODE:   alu_srcb_sel = 2'd3;
      ST_MEMADDR: begin
        alu_srca_sel = 1'b1;
        alu_srcb_sel = 2'd2;
      end
      ST_MEMRD:    mem_addr_sel = 1'b1;
      ST_MEMWRBCK: begin
        regWeRaw       = 1'b1;
        wrbck_data_sel = 1'b1;
      end
      ST_MEMWR: begin
        mem_addr_sel = 1'b1;
        memWeRaw     = 1'b1;
      end
      ST_RREXEC: begin
        alu_srca_sel = 1'b1;
        alu_op       = ALU_RR;
      end
      ST_RRWRBCK: begin
        regWeRaw     = 1'b1;
        wreg_dst_sel = 1'b1;
      end
      ST_BRANCH: begin
        alu_srca_sel = 1'b1;
        alu_op       = ALU_SUB;
        nxt_pc_sel   = 2'd1;
        pcWeRaw      = (opcode == OP_BNE) ? !zero : zero;
      end
      ST_JMP: begin
        nxt_pc_sel = 2'd2;
        pcWeRaw    = 1'b1;
      end
      ST_RIEXEC, ST_RIWRBCK: begin
        alu_srca_sel = 1'b1;
        alu_srcb_sel = 2'd2;
        alu_op       = riAluOp;
        imm_zext     = riZext;
        regWeRaw     = (stateReg == ST_RIWRBCK);
      end
      default: begin
      end
    endcase
  end

  // Strobes are gated by rst so an in-flight access is abandoned immediately.
  assign mem_req = memReqRaw && !rst;
  assign mem_we  = memWeRaw && !rst;
  assign ir_we   = irWeRaw && !rst;
  assign pc_we   = pcWeRaw && !rst;
  assign reg_we  = regWeRaw && !rst;

  assign trap       = (stateReg == ST_TRAP);
  assign trap_cause = causeReg;
  assign state_o    = stateReg;

endmodule

// File: tb/tb_multicyc_ctrl_fsm.sv
`timescale 1ns/1ps
module tb_multicyc_ctrl_fsm;

  localparam logic [5:0] OP_RR   = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT 1: TIMEOUT=4, TRAP_EN=1
  logic       rst, zero, memReady;
  logic [5:0] opcode;
  logic       memReq, memWe, memAddrSel, irWe, pcWe, srcA, immZext, regWe;
  logic       dstSel, wbSel, trap;
  logic [1:0] srcB, nxtPc, cause;
  logic [3:0] aluOp, state;
  logic [4:0] strobes;
  assign strobes = {memReq, memWe, irWe, pcWe, regWe};

  // DUT 2: TIMEOUT=0, TRAP_EN=0
  logic       rst2, zero2, memReady2;
  logic [5:0] opcode2;
  logic       memReq2, memWe2, memAddrSel2, irWe2, pcWe2, srcA2, immZext2, regWe2;
  logic       dstSel2, wbSel2, trap2;
  logic [1:0] srcB2, nxtPc2, cause2;
  logic [3:0] aluOp2, state2;

  multicyc_ctrl_fsm #(.TIMEOUT(4), .TRAP_EN(1'b1), .ALUOP_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(memReady),
    .mem_req(memReq), .mem_we(memWe), .mem_addr_sel(memAddrSel), .ir_we(irWe),
    .pc_we(pcWe), .alu_srca_sel(srcA), .alu_srcb_sel(srcB), .alu_op(aluOp),
    .imm_zext(immZext), .reg_we(regWe), .wreg_dst_sel(dstSel),
    .wrbck_data_sel(wbSel), .nxt_pc_sel(nxtPc), .trap(trap),
    .trap_cause(cause), .state_o(state)
  );

  multicyc_ctrl_fsm #(.TIMEOUT(0), .TRAP_EN(1'b0), .ALUOP_W(4)) dut2 (
    .clk(clk), .rst(rst2), .opcode(opcode2), .zero(zero2), .mem_ready(memReady2),
    .mem_req(memReq2), .mem_we(memWe2), .mem_addr_sel(memAddrSel2), .ir_we(irWe2),
    .pc_we(pcWe2), .alu_srca_sel(srcA2), .alu_srcb_sel(srcB2), .alu_op(aluOp2),
    .imm_zext(immZext2), .reg_we(regWe2), .wreg_dst_sel(dstSel2),
    .wrbck_data_sel(wbSel2), .nxt_pc_sel(nxtPc2), .trap(trap2),
    .trap_cause(cause2), .state_o(state2)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int irCnt = 0;
  int pcCnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are settled, so strobe counts are sampled here.
  task automatic tick();
    irCnt += int'(irWe);
    pcCnt += int'(pcWe);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Register-immediate instruction with memory always ready.
  task automatic riInstr(input logic [5:0] op, input logic [3:0] expAlu, input logic expZext,
                         input string name);
    opcode = op; memReady = 1'b1; cyc = 0; #1;
    chk({name, "_fetch_strobes"}, strobes, 5'b10110);
    chk({name, "_fetch_srcb"}, srcB, 2'd1);
    tick();
    chk({name, "_decode_state"}, state, 4'd1);
    chk({name, "_decode_srcb"}, srcB, 2'd3);
    tick();
    chk({name, "_exec_state"}, state, 4'd10);
    chk({name, "_exec_alu"}, aluOp, expAlu);
    chk({name, "_exec_zext"}, immZext, expZext);
    chk({name, "_exec_strobes"}, strobes, 5'b00000);
    tick();
    chk({name, "_wb_state"}, state, 4'd11);
    chk({name, "_wb_strobes"}, strobes, 5'b00001);
    chk({name, "_wb_dst"}, dstSel, 1'b0);
    chk({name, "_wb_alu"}, aluOp, expAlu);
    chk({name, "_wb_zext"}, immZext, expZext);
    tick();
    chk({name, "_cycles"}, cyc, 4);
    chk({name, "_back_fetch"}, state, 4'd0);
  endtask

  task automatic branchInstr(input logic [5:0] op, input logic z, input logic expPc,
                             input string name);
    opcode = op; zero = z; memReady = 1'b1; cyc = 0; #1;
    tick(); tick();
    chk({name, "_state"}, state, 4'd8);
    chk({name, "_pc_we"}, pcWe, expPc);
    chk({name, "_nxt_pc"}, nxtPc, 2'd1);
    chk({name, "_alu"}, aluOp, 4'd1);
    tick();
    chk({name, "_cycles"}, cyc, 3);
    chk({name, "_back_fetch"}, state, 4'd0);
  endtask

  task automatic resetDut1();
    rst = 1'b1; #1;
    chk("rst_state", state, 4'd0);
    chk("rst_trap", trap, 1'b0);
    chk("rst_cause", cause, 2'd0);
    @(posedge clk); #1;
    rst = 1'b0; memReady = 1'b0; #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b1; opcode = OP_ADDI; zero = 1'b0; memReady = 1'b0;
    rst2 = 1'b1; opcode2 = OP_BAD; zero2 = 1'b0; memReady2 = 1'b0;

    // Reset: strobes stay low even with ready asserted.
    #12; memReady = 1'b1; #1;
    chk("reset_strobes", strobes, 5'b00000);
    chk("reset_state", state, 4'd0);
    chk("reset_trap", trap, 1'b0);
    chk("reset_cause", cause, 2'd0);
    @(posedge clk); #1;
    rst = 1'b0; memReady = 1'b0; #1;
    chk("first_req", memReq, 1'b1);
    $display("reset check done");

    riInstr(OP_ADDI, 4'd0, 1'b0, "addi");
    $display("ADDI done");
    riInstr(OP_ORI, 4'd4, 1'b1, "ori");
    $display("ORI done");

    // RR
    opcode = OP_RR; memReady = 1'b1; #1;
    tick(); tick();
    chk("rr_exec_state", state, 4'd6);
    chk("rr_exec_alu", aluOp, 4'd6);
    chk("rr_exec_srcb", srcB, 2'd0);
    tick();
    chk("rr_wb_state", state, 4'd7);
    chk("rr_wb_strobes", strobes, 5'b00001);
    chk("rr_wb_dst", dstSel, 1'b1);
    chk("rr_wb_data", wbSel, 1'b0);
    tick();
    chk("rr_back_fetch", state, 4'd0);
    $display("RR done");

    // LW with 3 wait states in Fetch and MemRd.
    opcode = OP_LW; cyc = 0; irCnt = 0; pcCnt = 0; memReady = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      chk("lw_fetch_wait", strobes, 5'b10000);
      tick();
    end
    memReady = 1'b1; #1;
    chk("lw_fetch_ready", strobes, 5'b10110);
    tick();
    chk("lw_decode", state, 4'd1);
    tick();
    chk("lw_memaddr", state, 4'd2);
    chk("lw_memaddr_srcb", srcB, 2'd2);
    tick();
    memReady = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      chk("lw_memrd_state", state, 4'd3);
      chk("lw_memrd_strobes", strobes, 5'b10000);
      chk("lw_memrd_addr", memAddrSel, 1'b1);
      tick();
    end
    memReady = 1'b1; #1;
    chk("lw_memrd_ready", state, 4'd3);
    tick();
    chk("lw_wb_state", state, 4'd4);
    chk("lw_wb_strobes", strobes, 5'b00001);
    chk("lw_wb_data", wbSel, 1'b1);
    chk("lw_wb_dst", dstSel, 1'b0);
    tick();
    chk("lw_cycles", cyc, 11);
    chk("lw_ir_we_count", irCnt, 1);
    chk("lw_pc_we_count", pcCnt, 1);
    chk("lw_back_fetch", state, 4'd0);
    $display("LW done cycles=%0d", cyc);

    // Reset in the middle of a MemRd wait.
    opcode = OP_LW; memReady = 1'b1; #1;
    tick(); tick(); tick();
    memReady = 1'b0; #1;
    tick();
    chk("midrst_before_state", state, 4'd3);
    chk("midrst_before_req", memReq, 1'b1);
    #2; rst = 1'b1; #1;
    chk("midrst_strobes", strobes, 5'b00000);
    chk("midrst_state", state, 4'd0);
    @(posedge clk); #1;
    rst = 1'b0; #1;
    chk("midrst_first_req", strobes, 5'b10000);
    chk("midrst_trap", trap, 1'b0);
    $display("mid-MemRd reset done");

    branchInstr(OP_BEQ, 1'b1, 1'b1, "beq_z1");
    branchInstr(OP_BEQ, 1'b0, 1'b0, "beq_z0");
    branchInstr(OP_BNE, 1'b0, 1'b1, "bne_z0");
    branchInstr(OP_BNE, 1'b1, 1'b0, "bne_z1");
    $display("branches done");

    opcode = OP_J; memReady = 1'b1; cyc = 0; #1;
    tick(); tick();
    chk("j_state", state, 4'd9);
    chk("j_pc_we", pcWe, 1'b1);
    chk("j_nxt_pc", nxtPc, 2'd2);
    tick();
    chk("j_cycles", cyc, 3);
    $display("J done");

    // Illegal opcode with trap enabled.
    opcode = OP_BAD; memReady = 1'b1; #1;
    tick(); tick();
    chk("ill_state", state, 4'd12);
    chk("ill_trap", trap, 1'b1);
    chk("ill_cause", cause, 2'd1);
    for (int i = 0; i < 20; i++) begin
      memReady = i[0]; zero = i[1]; opcode = 6'(i * 7); #1;
      chk("ill_hold_strobes", strobes, 5'b00000);
      chk("ill_hold_state", state, 4'd12);
      chk("ill_hold_cause", cause, 2'd1);
      tick();
    end
    resetDut1();
    $display("illegal trap done");

    // SW timeout: 4 unanswered request cycles.
    opcode = OP_SW; memReady = 1'b1; #1;
    tick(); tick();
    chk("swto_memaddr", state, 4'd2);
    tick();
    memReady = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      chk("swto_wait_state", state, 4'd5);
      chk("swto_wait_strobes", strobes, 5'b11000);
      tick();
    end
    chk("swto_state", state, 4'd12);
    chk("swto_trap", trap, 1'b1);
    chk("swto_cause", cause, 2'd2);
    chk("swto_strobes", strobes, 5'b00000);
    resetDut1();
    $display("SW timeout done");

    // SW with ready on the 4th request cycle: no trap.
    opcode = OP_SW; memReady = 1'b1; #1;
    tick(); tick(); tick();
    memReady = 1'b0; #1;
    for (int i = 0; i < 3; i++) tick();
    memReady = 1'b1; #1;
    chk("swok_state", state, 4'd5);
    chk("swok_strobes", strobes, 5'b11000);
    tick();
    chk("swok_back_fetch", state, 4'd0);
    chk("swok_trap", trap, 1'b0);
    rst = 1'b1;
    $display("SW ready-on-last done");

    // DUT 2: illegal opcode is a NOP, watchdog disabled.
    @(posedge clk); #1;
    rst2 = 1'b0; opcode2 = OP_BAD; memReady2 = 1'b1; #1;
    chk("nop_fetch", state2, 4'd0);
    tick();
    chk("nop_decode", state2, 4'd1);
    tick();
    chk("nop_back_fetch", state2, 4'd0);
    chk("nop_trap", trap2, 1'b0);
    opcode2 = OP_SW; #1;
    tick(); tick(); tick();
    memReady2 = 1'b0; #1;
    for (int i = 0; i < 100; i++) tick();
    chk("nowd_state", state2, 4'd5);
    chk("nowd_trap", trap2, 1'b0);
    chk("nowd_req", memReq2, 1'b1);
    memReady2 = 1'b1; #1;
    tick();
    chk("nowd_back_fetch", state2, 4'd0);
    $display("TIMEOUT=0 / TRAP_EN=0 done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
